// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants and types for the register-file write arbiter.
//   NUM_REGS / ADDR_W / DATA_W : register file geometry (register 0 reads as zero)
//   state_e                    : arbiter phase (post-reset clear, then normal run)
//   req_id_e                   : write requester identity
//   wr_req_t                   : one write request (address + data)
package rf_pkg;

  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 32;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  typedef enum logic {
    REQ_WB  = 1'b0,
    REQ_DBG = 1'b1
  } req_id_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  // Addresses beyond the implemented registers are accepted but never written.
  function automatic logic isBadAddr(input logic [ADDR_W-1:0] addr);
    return addr >= ADDR_W'(NUM_REGS);
  endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bus bundle between the two write requesters and the arbiter.
//   wb_*      : pipeline writeback request (valid/reg/data in, ready out)
//   dbg_*     : debug/loader request (valid/reg/data in, ready out)
//   RegWre, WriteReg, WriteData : registered register-file write port
//   init_done : clear sequence finished
//   bad_addr  : one-cycle pulse for an accepted out-of-range address
// modport slave is the arbiter side, master is the requester/register-file side.
interface rf_write_arbiter_if;
  import rf_pkg::*;

  logic              wb_valid;
  logic [ADDR_W-1:0] wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic              wb_ready;

  logic              dbg_valid;
  logic [ADDR_W-1:0] dbg_reg;
  logic [DATA_W-1:0] dbg_data;
  logic              dbg_ready;

  logic              RegWre;
  logic [ADDR_W-1:0] WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic              init_done;
  logic              bad_addr;

  modport slave (
    input  wb_valid, wb_reg, wb_data,
    input  dbg_valid, dbg_reg, dbg_data,
    output wb_ready, dbg_ready,
    output RegWre, WriteReg, WriteData, init_done, bad_addr
  );

  modport master (
    output wb_valid, wb_reg, wb_data,
    output dbg_valid, dbg_reg, dbg_data,
    input  wb_ready, dbg_ready,
    input  RegWre, WriteReg, WriteData, init_done, bad_addr
  );

endinterface

// File: rtl/rf_write_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter.
//   clk, rst_n         : clock, async active-low reset
//   enable             : grants allowed this cycle
//   wbValid, dbgValid  : request lines
//   transfer           : a grant was taken this cycle; advance the priority
//   grantWb, grantDbg  : one-hot (or zero) grant, combinational
module rr_arbiter2
  import rf_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic wbValid,
  input  logic dbgValid,
  input  logic transfer,
  output logic grantWb,
  output logic grantDbg
);

  req_id_e lastGrant;

  // On contention the requester that did not win last time goes first.
  always_comb begin
    grantWb  = 1'b0;
    grantDbg = 1'b0;
    if (enable) begin
      if (wbValid && dbgValid) begin
        grantWb  = (lastGrant == REQ_DBG);
        grantDbg = (lastGrant == REQ_WB);
      end else begin
        grantWb  = wbValid;
        grantDbg = dbgValid;
      end
    end
  end

  // Reset to debug so writeback wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lastGrant <= REQ_DBG;
    end else if (transfer) begin
      lastGrant <= grantWb ? REQ_WB : REQ_DBG;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Owner of the register file write port.
// After reset it optionally clears registers 1..NUM_REGS-1, then arbitrates
// round-robin between writeback and debug requesters with one write per cycle.
//   CLK    : clock, all state on posedge
//   Reset  : async active-low reset
//   bus    : requester handshakes and registered write port (slave modport)
// Parameter CLEAR_ON_RESET: nonzero runs the clear sequence after reset.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input logic                CLK,
  input logic                Reset,
  rf_write_arbiter_if.slave  bus
);

  localparam state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;

  state_e            state;
  state_e            stateNext;
  logic [ADDR_W-1:0] clrCnt;
  logic [ADDR_W-1:0] clrCntNext;

  logic              regWreQ;
  logic              regWreNext;
  logic [ADDR_W-1:0] writeRegQ;
  logic [ADDR_W-1:0] writeRegNext;
  logic [DATA_W-1:0] writeDataQ;
  logic [DATA_W-1:0] writeDataNext;
  logic              initDoneQ;
  logic              initDoneNext;
  logic              badAddrQ;
  logic              badAddrNext;

  logic              grantEn;
  logic              grantWb;
  logic              grantDbg;
  logic              transfer;
  wr_req_t           selReq;

  // Readies are forced low while Reset is held, even when resetting into RUN.
  assign grantEn  = (state == RUN) && Reset;
  assign transfer = grantWb || grantDbg;

  rr_arbiter2 u_arb (
    .clk      (CLK),
    .rst_n    (Reset),
    .enable   (grantEn),
    .wbValid  (bus.wb_valid),
    .dbgValid (bus.dbg_valid),
    .transfer (transfer),
    .grantWb  (grantWb),
    .grantDbg (grantDbg)
  );

  // Request selected by the current grant.
  always_comb begin
    selReq = grantWb ? wr_req_t'({bus.wb_reg, bus.wb_data})
                     : wr_req_t'({bus.dbg_reg, bus.dbg_data});
  end

  // State register and write-port registers.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state      <= RESET_STATE;
      clrCnt     <= ADDR_W'(1);
      regWreQ    <= 1'b0;
      writeRegQ  <= '0;
      writeDataQ <= '0;
      initDoneQ  <= 1'b0;
      badAddrQ   <= 1'b0;
    end else begin
      state      <= stateNext;
      clrCnt     <= clrCntNext;
      regWreQ    <= regWreNext;
      writeRegQ  <= writeRegNext;
      writeDataQ <= writeDataNext;
      initDoneQ  <= initDoneNext;
      badAddrQ   <= badAddrNext;
    end
  end

  // Next state and next write-port values.
  always_comb begin
    stateNext     = state;
    clrCntNext    = clrCnt;
    regWreNext    = 1'b0;
    writeRegNext  = writeRegQ;
    writeDataNext = writeDataQ;
    initDoneNext  = initDoneQ;
    badAddrNext   = 1'b0;

    unique case (state)
      CLEAR: begin
        regWreNext    = 1'b1;
        writeRegNext  = clrCnt;
        writeDataNext = '0;
        clrCntNext    = clrCnt + ADDR_W'(1);
        if (clrCnt == ADDR_W'(NUM_REGS - 1)) begin
          stateNext = RUN;
        end
      end
      RUN: begin
        initDoneNext = 1'b1;
        if (transfer) begin
          writeRegNext  = selReq.addr;
          writeDataNext = selReq.data;
          // Register 0 and out-of-range addresses are consumed without a write.
          if (isBadAddr(selReq.addr)) begin
            badAddrNext = 1'b1;
          end else if (selReq.addr != '0) begin
            regWreNext = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  assign bus.wb_ready  = grantWb;
  assign bus.dbg_ready = grantDbg;
  assign bus.RegWre    = regWreQ;
  assign bus.WriteReg  = writeRegQ;
  assign bus.WriteData = writeDataQ;
  assign bus.init_done = initDoneQ;
  assign bus.bad_addr  = badAddrQ;

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Owns the single write port of the 16-entry register file.
- After reset, sequences a clear of registers 1..NUM_REGS-1 to zero.
- Then arbitrates, round-robin, between two write requesters: pipeline writeback (wb) and debug/loader port (dbg). Each uses a valid/ready handshake.
- Drives RegWre/WriteReg/WriteData from registers on posedge CLK. The register file commits on the following negedge CLK.

Parameters:
- NUM_REGS, 16, number of implemented registers; register 0 is hard-wired zero.
- ADDR_W, 5, register address width (matches register file WriteReg).
- DATA_W, 32, register data width.
- CLEAR_ON_RESET, 1, 1 = run clear sequence after reset; 0 = enter RUN directly.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- Reset  in  1  asynchronous, active-low reset.
- wb_valid  in  1  writeback request.
- wb_reg  in  ADDR_W  writeback destination register.
- wb_data  in  DATA_W  writeback data.
- wb_ready  out  1  writeback request accepted this cycle.
- dbg_valid  in  1  debug request.
- dbg_reg  in  ADDR_W  debug destination register.
- dbg_data  in  DATA_W  debug data.
- dbg_ready  out  1  debug request accepted this cycle.
- RegWre  out  1  register file write enable (registered).
- WriteReg  out  ADDR_W  register file write address (registered).
- WriteData  out  DATA_W  register file write data (registered).
- init_done  out  1  clear sequence complete; stays high until next reset.
- bad_addr  out  1  one-cycle pulse: accepted request had reg >= NUM_REGS.

Behaviour:
- Reset (Reset=0, asynchronous, any time including mid-clear or mid-write):
  - RegWre=0, WriteReg=0, WriteData=0, init_done=0, bad_addr=0.
  - clear counter=1.
  - last_grant=dbg, so wb wins the first tie.
  - state=CLEAR (RUN if CLEAR_ON_RESET=0, with init_done=1 on the first posedge after release).
  - wb_ready=dbg_ready=0 while Reset=0.
- State CLEAR:
  - wb_ready=dbg_ready=0.
  - Each posedge: RegWre<=1, WriteReg<=counter, WriteData<=0, counter++.
  - Covers registers 1..NUM_REGS-1 on consecutive cycles (15 cycles at default).
  - On the posedge issuing register NUM_REGS-1, state<=RUN.
  - On the next posedge: init_done<=1, RegWre<=0 unless a request is accepted.
- State RUN, grant (combinational from valids and last_grant):
  - Only wb_valid: grant wb.
  - Only dbg_valid: grant dbg.
  - Both valid: grant the requester not equal to last_grant.
  - Neither valid: no grant.
  - ready is high only for the granted requester. At most one ready per cycle.
  - ready may depend combinationally on both valids. Requesters must not make valid depend on ready.
- Transfer:
  - Transfer = valid && ready at posedge N.
  - RegWre/WriteReg/WriteData reflect it during cycle N+1. Latency 1 cycle; throughput 1 write/cycle.
  - last_grant updates only on a transfer.
  - No transfer in a cycle: RegWre<=0; WriteReg/WriteData hold their previous values.
- Address rules:
  - reg==0: accepted, RegWre<=0 (dropped silently), bad_addr stays 0.
  - reg>=NUM_REGS: accepted, RegWre<=0, bad_addr<=1 for exactly one cycle.
  - Either case still updates last_grant.
- A requester holding valid with stable reg/data is guaranteed acceptance within 2 cycles under continuous contention.
- No internal buffering; back-pressure is provided solely via ready.

Decomposition:
- Shared package rf_pkg:
  - constants NUM_REGS, ADDR_W, DATA_W.
  - state enum {CLEAR, RUN}.
  - requester ID enum {REQ_WB, REQ_DBG}.
- One natural sub-module: rr_arbiter2 (two-input round-robin grant plus last_grant register, update-on-transfer input).
- Clear FSM and output registers remain in rf_write_arbiter.

Test Plan:
- Reset release, no requests -> RegWre=1 for 15 consecutive cycles with WriteReg=1..15, WriteData=0. init_done=1 on cycle 16. Both readys 0 throughout clear.
- After init, wb_valid=1, wb_reg=3, wb_data=32'hDEADBEEF for one cycle -> wb_ready=1. Next cycle RegWre=1, WriteReg=3, WriteData=32'hDEADBEEF. Cycle after that RegWre=0.
- Both valid continuously (wb reg 4 data 0x11; dbg reg 5 data 0x22) -> grants alternate wb,dbg,wb,dbg starting with wb. RegWre high every cycle; WriteReg alternates 4,5.
- dbg_valid, dbg_reg=20 -> dbg_ready=1; next cycle bad_addr=1 for one cycle, RegWre=0. Then dbg_reg=0 -> accepted, RegWre=0, bad_addr=0.
- Reset asserted at clear cycle 7 (WriteReg=7), released 2 cycles later -> outputs 0 immediately on assertion. Clear restarts at WriteReg=1. init_done low until the full 15-cycle sequence completes.
- CLEAR_ON_RESET=0, wb and dbg both valid on the first cycle after reset release -> init_done=1 after first posedge, wb granted first, no clear writes issued.
